// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet pixel types, tap indices and pooling constants
//
// Contents:
//   PIX_WIDTH_DEFAULT  default signed pixel width used by layer blocks
//   TAP_*              index of each 2x2 window tap in a per-filter tap vector
//   POOL_LAT           fixed latency of the 2x2 max-pool pipeline (cycles)
//   pix_t              signed pixel at the default width
package lenet_pkg;

    localparam int PIX_WIDTH_DEFAULT = 16;

    localparam int TAP_CUR    = 0;
    localparam int TAP_LEFT   = 1;
    localparam int TAP_UP     = 2;
    localparam int TAP_UPLEFT = 3;

    localparam int POOL_LAT = 2;

    typedef logic signed [PIX_WIDTH_DEFAULT-1:0] pix_t;

endpackage

// File: rtl/max2_signed.sv
// rtl/max2_signed.sv - registered two-input signed max with optional negative clamp
//
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset, clears q
//   en   in   load enable; q holds when low
//   a    in   signed operand
//   b    in   signed operand
//   q    out  registered max(a, b), or 0 when CLAMP_NEG and the max is negative
module max2_signed #(
    parameter int W         = 16,
    parameter bit CLAMP_NEG = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] q
);

    logic signed [W-1:0] mx;
    logic signed [W-1:0] nxt;

    always_comb begin
        // On a tie either operand is the correct answer, so >= needs no special case.
        mx  = (a >= b) ? a : b;
        nxt = mx;
        if (CLAMP_NEG && mx[W-1]) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/maxpool_2x2_stride2.sv
// rtl/maxpool_2x2_stride2.sv - 2x2 stride-2 signed max pooling over NUM_FILT feature maps
//
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled results to 0.
//
// Ports:
//   mp_clk           in   clock
//   mp_rst           in   asynchronous active-high reset
//   mp_en_i          in   window valid; advances position counters and stage-1 capture
//   mp_win_i         in   per-filter taps [TAP_CUR, TAP_LEFT, TAP_UP, TAP_UPLEFT]
//   mp_out_o         out  pooled max per filter; holds its value when mp_valid_o is low
//   mp_valid_o       out  mp_out_o carries a stride-2 result this cycle
//   mp_frame_done_o  out  pulse with the last pooled output of a frame
module maxpool_2x2_stride2 import lenet_pkg::*; #(
    parameter int NUM_FILT  = 6,
    parameter int PIX_WIDTH = PIX_WIDTH_DEFAULT,
    parameter int IMG_COLS  = 28,
    parameter int IMG_ROWS  = 28
) (
    input  logic                                     mp_clk,
    input  logic                                     mp_rst,
    input  logic                                     mp_en_i,
    input  logic [NUM_FILT-1:0][3:0][PIX_WIDTH-1:0]  mp_win_i,
    output logic [NUM_FILT-1:0][PIX_WIDTH-1:0]       mp_out_o,
    output logic                                     mp_valid_o,
    output logic                                     mp_frame_done_o
);

    // The pipeline below is exactly two register stages deep.
    if (POOL_LAT != 2) begin : g_lat_check
        $error("maxpool_2x2_stride2 is built for a two-stage pipeline");
    end

`ifdef MAXPOOL_RELU_EN
    localparam bit RELU_CLAMP = 1'b1;
`else
    localparam bit RELU_CLAMP = 1'b0;
`endif

    localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
    localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);

    // Last odd row/column: with odd dimensions the trailing row/column never
    // completes a window, so the frame ends on the last kept window instead.
    localparam logic [CW-1:0] COL_KEEP_LAST = CW'(IMG_COLS - 1 - (IMG_COLS % 2));
    localparam logic [RW-1:0] ROW_KEEP_LAST = RW'(IMG_ROWS - 1 - (IMG_ROWS % 2));

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          at_col_end;
    logic          at_row_end;
    logic          keep;
    logic          at_keep_last;

    logic          valid_s1;
    logic          keep_s1;
    logic          last_s1;
    logic          stage2_en;

    assign at_col_end   = (col_cnt == COL_LAST);
    assign at_row_end   = (row_cnt == ROW_LAST);
    // Odd row and odd column: the current tap closes a full 2x2 window.
    assign keep         = col_cnt[0] & row_cnt[0];
    assign at_keep_last = (col_cnt == COL_KEEP_LAST) && (row_cnt == ROW_KEEP_LAST);

    always_ff @(posedge mp_clk or posedge mp_rst) begin
        if (mp_rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (mp_en_i) begin
            if (at_col_end) begin
                col_cnt <= '0;
                row_cnt <= at_row_end ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Stage-1 side-band. valid_s1 follows mp_en_i every cycle so a gap never
    // re-emits an old window; keep/last only load with a window.
    always_ff @(posedge mp_clk or posedge mp_rst) begin
        if (mp_rst) begin
            valid_s1 <= 1'b0;
            keep_s1  <= 1'b0;
            last_s1  <= 1'b0;
        end else begin
            valid_s1 <= mp_en_i;
            if (mp_en_i) begin
                keep_s1 <= keep;
                last_s1 <= at_keep_last;
            end
        end
    end

    // Stage 2 only loads on a kept window so mp_out_o holds between results.
    assign stage2_en = valid_s1 & keep_s1;

    always_ff @(posedge mp_clk or posedge mp_rst) begin
        if (mp_rst) begin
            mp_valid_o      <= 1'b0;
            mp_frame_done_o <= 1'b0;
        end else begin
            mp_valid_o      <= stage2_en;
            mp_frame_done_o <= stage2_en & last_s1;
        end
    end

    for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
        logic signed [PIX_WIDTH-1:0] m0;
        logic signed [PIX_WIDTH-1:0] m1;

        max2_signed #(
            .W         (PIX_WIDTH),
            .CLAMP_NEG (1'b0)
        ) u_max_row_cur (
            .clk (mp_clk),
            .rst (mp_rst),
            .en  (mp_en_i),
            .a   (mp_win_i[f][TAP_CUR]),
            .b   (mp_win_i[f][TAP_LEFT]),
            .q   (m0)
        );

        max2_signed #(
            .W         (PIX_WIDTH),
            .CLAMP_NEG (1'b0)
        ) u_max_row_up (
            .clk (mp_clk),
            .rst (mp_rst),
            .en  (mp_en_i),
            .a   (mp_win_i[f][TAP_UP]),
            .b   (mp_win_i[f][TAP_UPLEFT]),
            .q   (m1)
        );

        // Clamping in the final stage keeps the latency identical with or without ReLU.
        max2_signed #(
            .W         (PIX_WIDTH),
            .CLAMP_NEG (RELU_CLAMP)
        ) u_max_final (
            .clk (mp_clk),
            .rst (mp_rst),
            .en  (stage2_en),
            .a   (m0),
            .b   (m1),
            .q   (mp_out_o[f])
        );
    end

endmodule

// File: tb/tb_maxpool_2x2_stride2.sv
// tb/tb_maxpool_2x2_stride2.sv - self-checking bench for maxpool_2x2_stride2
module tb_maxpool_2x2_stride2;

    localparam int NF   = 6;
    localparam int PW   = 16;
    localparam int COLS = 28;
    localparam int ROWS = 28;
    localparam int FRAME = COLS * ROWS;

    typedef logic [NF-1:0][3:0][PW-1:0] win_t;
    typedef logic [NF-1:0][PW-1:0]      out_t;

    typedef struct {
        out_t out;
        bit   fd;
        int   cyc;
    } exp_t;

    typedef struct {
        logic [3:0][PW-1:0] taps;
        logic [PW-1:0]      raw;
        logic [PW-1:0]      relu;
    } vec_t;

    logic mp_clk = 1'b0;
    logic mp_rst = 1'b0;
    logic mp_en_i = 1'b0;
    win_t mp_win_i = '0;
    out_t mp_out_o;
    logic mp_valid_o;
    logic mp_frame_done_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int m_col  = 0;
    int m_row  = 0;

    exp_t sb[$];
    int   vcyc[$];
    int   fdcyc[$];
    int   fd_at_vidx[$];

    maxpool_2x2_stride2 #(
        .NUM_FILT  (NF),
        .PIX_WIDTH (PW),
        .IMG_COLS  (COLS),
        .IMG_ROWS  (ROWS)
    ) dut (
        .mp_clk          (mp_clk),
        .mp_rst          (mp_rst),
        .mp_en_i         (mp_en_i),
        .mp_win_i        (mp_win_i),
        .mp_out_o        (mp_out_o),
        .mp_valid_o      (mp_valid_o),
        .mp_frame_done_o (mp_frame_done_o)
    );

    always #5 mp_clk = ~mp_clk;

    always @(posedge mp_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic out_t pool(input win_t w);
        out_t o;
        for (int f = 0; f < NF; f++) begin
            logic signed [PW-1:0] m;
            m = w[f][0];
            for (int t = 1; t < 4; t++) begin
                if ($signed(w[f][t]) > m) m = w[f][t];
            end
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = '0;
`endif
            o[f] = m;
        end
        return o;
    endfunction

    task automatic model_step(input win_t w);
        exp_t e;
        if (m_col[0] && m_row[0]) begin
            e.out = pool(w);
            e.fd  = (m_row == ROWS - 1) && (m_col == COLS - 1);
            e.cyc = cyc + 2;
            sb.push_back(e);
        end
        if (m_col == COLS - 1) begin
            m_col = 0;
            m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic drive(input bit en, input win_t w);
        @(negedge mp_clk);
        mp_en_i  = en;
        mp_win_i = w;
        if (en) model_step(w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge mp_clk);
        #2;
        mp_rst  = 1'b1;
        mp_en_i = 1'b0;
        sb.delete();
        m_col = 0;
        m_row = 0;
        @(negedge mp_clk);
        #2;
        mp_rst = 1'b0;
        vcyc.delete();
        fdcyc.delete();
        fd_at_vidx.delete();
    endtask

    function automatic win_t ramp_win(input int k);
        win_t w;
        for (int f = 0; f < NF; f++)
            for (int t = 0; t < 4; t++) w[f][t] = PW'(4 * k);
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int f = 0; f < NF; f++)
            for (int t = 0; t < 4; t++) w[f][t] = PW'($urandom);
        return w;
    endfunction

    function automatic vec_t mkv(input int a0, input int a1, input int a2, input int a3,
                                 input int raw, input int relu);
        vec_t v;
        v.taps[0] = PW'(a0);
        v.taps[1] = PW'(a1);
        v.taps[2] = PW'(a2);
        v.taps[3] = PW'(a3);
        v.raw     = PW'(raw);
        v.relu    = PW'(relu);
        return v;
    endfunction

    // Scoreboard: every valid output must match the oldest expected result.
    always @(negedge mp_clk) begin
        if (mp_frame_done_o === 1'b1 && mp_valid_o !== 1'b1)
            chk("frame_done_without_valid", 128'(mp_valid_o), 128'(1));
        if (mp_valid_o === 1'b1) begin
            vcyc.push_back(cyc);
            if (mp_frame_done_o === 1'b1) begin
                fdcyc.push_back(cyc);
                fd_at_vidx.push_back(vcyc.size() - 1);
            end
            if (sb.size() == 0) begin
                chk("unexpected_valid", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pool_out", 128'(mp_out_o), 128'(e.out));
                chk("frame_done", 128'(mp_frame_done_o), 128'(e.fd));
                chk("out_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        vec_t vt[8];
        int   s_cyc;
        int   n_en;
        int   iter;
        win_t w;
        logic [PW-1:0] want;

        vt[0] = mkv(-5, 7, 3, -32768, 7, 7);
        vt[1] = mkv(-9, -3, -20, -32768, -3, 0);
        vt[2] = mkv(-32768, -32768, -32768, -32768, -32768, 0);
        vt[3] = mkv(100, 100, 100, 100, 100, 100);
        vt[4] = mkv(0, -1, -1, -1, 0, 0);
        vt[5] = mkv(32767, -32768, 0, 0, 32767, 32767);
        vt[6] = mkv(-4, -3, -2, -1, -1, 0);
        vt[7] = mkv(-32768, -32767, -32768, -32768, -32767, 0);

        // Reset state
        do_reset();
        chk("reset_out", 128'(mp_out_o), 128'(0));
        chk("reset_valid", 128'(mp_valid_o), 128'(0));
        chk("reset_frame_done", 128'(mp_frame_done_o), 128'(0));

        // Table vectors, each presented at position (1,1) of a fresh frame.
        // Filter f sees the taps rotated by f so the winner moves between tap slots.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int k = 0; k < COLS + 1; k++) drive(1'b1, '0);
            for (int f = 0; f < NF; f++)
                for (int t = 0; t < 4; t++) w[f][t] = vt[v].taps[(t + f) % 4];
            drive(1'b1, w);
            idle(1);
            chk($sformatf("vec%0d_valid_early", v), 128'(mp_valid_o), 128'(0));
            idle(1);
            chk($sformatf("vec%0d_valid", v), 128'(mp_valid_o), 128'(1));
`ifdef MAXPOOL_RELU_EN
            want = vt[v].relu;
`else
            want = vt[v].raw;
`endif
            for (int f = 0; f < NF; f++)
                chk($sformatf("vec%0d_out_f%0d", v, f), 128'(mp_out_o[f]), 128'(want));
            idle(2);
        end

        // Two back-to-back frames of ramp taps, no gaps.
        do_reset();
        s_cyc = cyc + 1;
        for (int k = 0; k < 2 * FRAME; k++) drive(1'b1, ramp_win(k % FRAME));
        idle(4);
        chk("ramp_valid_count", 128'(vcyc.size()), 128'(2 * FRAME / 4));
        chk("ramp_fd_count", 128'(fdcyc.size()), 128'(2));
        if (vcyc.size() > 0)
            chk("ramp_first_valid_cycle", 128'(vcyc[0]), 128'(s_cyc + 29 + 2));
        if (fd_at_vidx.size() > 0) begin
            chk("ramp_fd_on_196th", 128'(fd_at_vidx[0]), 128'(FRAME / 4 - 1));
            if (vcyc.size() > FRAME / 4)
                chk("b2b_gap_after_fd", 128'(vcyc[FRAME / 4] - fdcyc[0]), 128'(30));
        end

        // Two frames with roughly 50% enable duty and random taps.
        do_reset();
        n_en = 0;
        iter = 0;
        while (n_en < 2 * FRAME && iter < 20000) begin
            if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, rand_win());
                n_en++;
            end else begin
                drive(1'b0, rand_win());
            end
            iter++;
        end
        idle(4);
        chk("rand_enables_done", 128'(n_en), 128'(2 * FRAME));
        chk("rand_valid_count", 128'(vcyc.size()), 128'(2 * FRAME / 4));
        chk("rand_fd_count", 128'(fdcyc.size()), 128'(2));

        // Reset while a kept window (row 11, col 3) is still in the pipeline.
        do_reset();
        for (int k = 0; k < 11 * COLS + 4; k++) drive(1'b1, ramp_win(k));
        @(negedge mp_clk);
        #2;
        mp_rst  = 1'b1;
        mp_en_i = 1'b0;
        sb.delete();
        m_col = 0;
        m_row = 0;
        #1;
        chk("midreset_valid", 128'(mp_valid_o), 128'(0));
        chk("midreset_out", 128'(mp_out_o), 128'(0));
        @(negedge mp_clk);
        #2;
        mp_rst = 1'b0;
        vcyc.delete();
        fdcyc.delete();
        fd_at_vidx.delete();
        for (int k = 0; k < COLS + 1; k++) drive(1'b1, ramp_win(k + 500));
        idle(3);
        chk("midreset_no_early_output", 128'(vcyc.size()), 128'(0));
        drive(1'b1, ramp_win(7));
        idle(3);
        chk("midreset_first_at_1_1", 128'(vcyc.size()), 128'(1));

        chk("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
